systolic_feeder: RTL
====================

# systolic_feeder

Input staging stage that sits directly upstream of the N×N `PE` systolic array. It accepts one k-slice per beat over a valid/ready handshake: column k of A (N elements) and row k of B (N elements). It applies the diagonal skew the array needs, so lane i/j reaches the edge PEs i/j cycles later than lane 0. After the last slice it tracks the array drain and pulses `done` on the cycle the final accumulation lands in PE[N-1][N-1].

## Interface
- `WIDTH`, 8, element width; matches PE `WIDTH`.
- `N`, 2, array dimension (lanes per side), N ≥ 1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: slice present.
- `in_ready` output 1: feeder can accept a slice.
- `in_last` input 1: qualifies the final slice (k = K-1) of the job.
- `a_vec` input N·WIDTH: A[i][k], lane i at bits [i·WIDTH +: WIDTH].
- `b_vec` input N·WIDTH: B[k][j], lane j at bits [j·WIDTH +: WIDTH].
- `a_edge` output N·WIDTH: left-edge feed, lane i to PE[i][0] `a_in`.
- `b_edge` output N·WIDTH: top-edge feed, lane j to PE[0][j] `b_in`.
- `a_valid` output N: per-row valid to the row-0-column PE.
- `b_valid` output N: per-column valid to the column-0-row PE.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse, all products accumulated.

## Operation
- A slice is accepted when `in_valid && in_ready` on a rising edge.
- FSM states:
  - IDLE: `in_ready`=1. An accept moves to STREAM, or to FLUSH if `in_last` is also set.
  - STREAM: `in_ready`=1. An accept with `in_last` moves to FLUSH.
  - FLUSH: `in_ready`=0. The drain counter loads 2N-2 on entry and decrements each cycle. At 0, go to IDLE and assert `done` for one cycle.
- Skew: lane i (A and B alike) passes through an i+1-deep register line. The first stage captures the data and the accept flag; stages shift every cycle unconditionally.
- Valid per lane is the delayed accept flag. A cycle with no accept injects a bubble (valid 0) that travels with the skew, so alignment between lanes is preserved.
- When a lane's valid is 0, its data output is 0.
- No arithmetic on data. Elements pass bit-exact.
- The feeder never clears the array. Consecutive jobs accumulate unless the array is reset.
- The drain counter width is clog2(2N-1), minimum 1 bit.

## Timing
- Reset values: `in_ready`=1 (IDLE), `a_edge`/`b_edge`=0, `a_valid`/`b_valid`=0, `busy`=0, `done`=0, all skew stages 0, state IDLE, drain counter 0.
- Let E0 be the accept edge of a slice.
  - Lane i presents that slice after edge E0+i, i.e. latency i+1 register stages.
  - PE[i][j] accumulates it at E0+i+j+1.
- Let EL be the accept edge of the `in_last` slice.
  - `in_ready` is 0 from EL through the FLUSH dwell.
  - `done`=1 after edge EL+2N-1, simultaneous with the final `c_out` update in PE[N-1][N-1].
  - `in_ready` returns to 1 in the cycle after `done`.
- `in_last` is ignored without `in_valid`. `a_vec`/`b_vec` are ignored when not accepted.
- K=1 (`in_last` on the first beat): IDLE goes directly to FLUSH. Timing is identical.
- N=1: no skew beyond one stage. Drain is 1 cycle; `done` follows EL+1.
- `rst_n` low mid-STREAM or mid-FLUSH: everything returns to reset values immediately. In-flight slices are discarded and no `done` is issued.
- `busy` is high in STREAM and FLUSH, and low in the `done` cycle.

## Structure
- Shared package `tpu_pkg`:
  - `feeder_state_t` enum (IDLE, STREAM, FLUSH).
  - Default `WIDTH`/`N` constants shared with the array top.
- Sub-module `skew_line` (parameters `WIDTH`, `DEPTH`): a shift register of {valid, data} with async active-low reset and zeroed data on invalid.
  - Instantiated once per A lane and once per B lane with DEPTH=i+1.
- The FSM and drain counter live in `systolic_feeder`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0 and `in_ready`=1; after release, `busy`=0.
- N=2, K=2 back-to-back:
  - Stimulus: slice k=0 with a_vec={A10=3, A00=1}, b_vec={B01=4, B00=2}; then slice k=1 with `in_last`, A={2,5}, B={6,7}.
  - Required: lane-0 outputs at EL-1 and EL; lane 1 one cycle later; `done` after EL+3.
  - With 2×2 PEs attached: C = A·B (C00 = 1·2 + 2·6 = 14).
- Bubble: insert one idle cycle between slices → the `a_valid`/`b_valid` gap is visible on all lanes, offset by lane index; the C result is unchanged; `done` is still EL+3.
- K=1: a single beat with `in_last` from IDLE → `in_ready`=0 for 3 cycles, then a `done` pulse, then `in_ready`=1.
- Backpressure: hold `in_valid`=1 during FLUSH → no accept, and the next job starts only after `done`.
- Reset mid-FLUSH: drop `rst_n` one cycle after EL → no `done` pulse, outputs 0, state IDLE.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and default dimensions for the systolic array and its feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } feeder_state_t;

   localparam int TPU_WIDTH = 8;
   localparam int TPU_N     = 2;

   // Drain counter must hold 2N-2; never narrower than one bit (N=1 case).
   function automatic int drain_cnt_w(input int n);
      int w;
      w = $clog2(2 * n - 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth {valid, data} delay line; data is forced to zero when not valid.
// Latency: DEPTH cycles from capture to out_valid/out_data.
// Backpressure: none; stages shift every cycle unconditionally.
module skew_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0]            vld_q, vld_d;
   logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;

   // Stage 0 captures the accept flag and (gated) data; later stages just shift.
   always_comb begin
      vld_d    = vld_q;
      dat_d    = dat_q;
      vld_d[0] = in_valid;
      dat_d[0] = in_valid ? in_data : '0;
      for (int s = 1; s < DEPTH; s++) begin
         vld_d[s] = vld_q[s-1];
         dat_d[s] = dat_q[s-1];
      end
   end

   // Delay-line registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews A-column / B-row slices onto the systolic array edges and signals drain completion.
// Latency: lane i presents a slice i+1 cycles after accept; done follows the last accept by 2N-1 cycles.
// Backpressure: in_ready drops from the last-slice accept until the cycle after done.
module systolic_feeder
   import tpu_pkg::*;
#(
   parameter int WIDTH = TPU_WIDTH,
   parameter int N     = TPU_N
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [N*WIDTH-1:0] a_vec,
   input  logic [N*WIDTH-1:0] b_vec,
   output logic [N*WIDTH-1:0] a_edge,
   output logic [N*WIDTH-1:0] b_edge,
   output logic [N-1:0]       a_valid,
   output logic [N-1:0]       b_valid,
   output logic               busy,
   output logic               done
);

   localparam int            CW         = drain_cnt_w(N);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(2 * N - 2);

   feeder_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          accept;

   // The done cycle still blocks input so a new job cannot overlap the final accumulation.
   assign in_ready = (state_q != FLUSH) && !done_q;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

   // Next-state, drain countdown and done pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = in_last ? FLUSH : STREAM;
               if (in_last) cnt_d = DRAIN_LOAD;
            end
         end
         STREAM: begin
            if (accept && in_last) begin
               state_d = FLUSH;
               cnt_d   = DRAIN_LOAD;
            end
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // One delay line per lane, depth lane+1, so bubbles keep their diagonal alignment.
   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_line #(
         .WIDTH (WIDTH),
         .DEPTH (i + 1)
      ) u_a_skew (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (accept),
         .in_data   (a_vec[i*WIDTH +: WIDTH]),
         .out_valid (a_valid[i]),
         .out_data  (a_edge[i*WIDTH +: WIDTH])
      );

      skew_line #(
         .WIDTH (WIDTH),
         .DEPTH (i + 1)
      ) u_b_skew (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (accept),
         .in_data   (b_vec[i*WIDTH +: WIDTH]),
         .out_valid (b_valid[i]),
         .out_data  (b_edge[i*WIDTH +: WIDTH])
      );
   end

endmodule
